// File: rtl/vx_issue_sched_mc_pkg.sv
// Shared width helpers for the multi-channel issue scheduler and its round-robin picker.
package vx_issue_sched_mc_pkg;

  // Index width that never collapses to zero bits, even for a single requester.
  function automatic int wid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int reg_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_picker.sv
// Round-robin picker: first requester at or after ptr (wrapping), one-hot grant and next pointer.
module vx_rr_picker
  import vx_issue_sched_mc_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int IDX_W = wid_width(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  input  logic                en,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    idx,
  output logic                valid,
  output logic [IDX_W-1:0]    ptr_next
);

  int cand;

  // Scan offsets from far to near so the nearest requester is the last to win.
  always_comb begin
    cand  = 0;
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NUM_REQS;
      if (req[cand]) begin
        idx   = IDX_W'(cand);
        valid = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (en && valid) begin
      grant[idx] = 1'b1;
    end
  end

  assign ptr_next = (int'(idx) == NUM_REQS - 1) ? '0 : idx + 1'b1;

endmodule

// File: rtl/vx_issue_sched_mc.sv
// Issue scheduler: per-warp busy-register tracking, RAW/WAW blocking, round-robin pick into a registered stage.
// Define ISSUE_WB_BYPASS_EN to let same-cycle eop writebacks unblock dependents immediately.
module vx_issue_sched_mc
  import vx_issue_sched_mc_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_REGS     = 32,
  parameter int NUM_WB_PORTS = 2,
  parameter int DATAW        = 64,
  localparam int WID_W = wid_width(NUM_WARPS),
  localparam int RB    = reg_width(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WARPS-1:0]          ibuf_valid,
  input  logic [NUM_WARPS*DATAW-1:0]    ibuf_data,
  input  logic [NUM_WARPS-1:0]          ibuf_wb,
  input  logic [NUM_WARPS*RB-1:0]       ibuf_rd,
  input  logic [NUM_WARPS*RB-1:0]       ibuf_rs1,
  input  logic [NUM_WARPS*RB-1:0]       ibuf_rs2,
  input  logic [NUM_WARPS*RB-1:0]       ibuf_rs3,
  output logic [NUM_WARPS-1:0]          ibuf_ready,
  input  logic [NUM_WB_PORTS-1:0]       wb_valid,
  input  logic [NUM_WB_PORTS*WID_W-1:0] wb_wid,
  input  logic [NUM_WB_PORTS*RB-1:0]    wb_rd,
  input  logic [NUM_WB_PORTS-1:0]       wb_eop,
  output logic                          out_valid,
  output logic [WID_W-1:0]              out_wid,
  output logic [DATAW-1:0]              out_data,
  input  logic                          out_ready
);

  typedef struct packed {
    logic             wb;
    logic [RB-1:0]    rd;
    logic [RB-1:0]    rs1;
    logic [RB-1:0]    rs2;
    logic [RB-1:0]    rs3;
    logic [DATAW-1:0] data;
  } sched_in_t;

  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic [RB-1:0]    rd;
    logic             eop;
  } wb_rel_t;

  sched_in_t             sin         [NUM_WARPS];
  wb_rel_t               rel         [NUM_WB_PORTS];
  logic [NUM_REGS-1:0]   busy        [NUM_WARPS];
  logic [NUM_REGS-1:0]   clear_mask  [NUM_WARPS];
  logic [NUM_REGS-1:0]   set_mask    [NUM_WARPS];
  logic [NUM_REGS-1:0]   hazard_view [NUM_WARPS];
  logic [NUM_WARPS-1:0]  eligible;
  logic [NUM_WARPS-1:0]  grant;
  logic [WID_W-1:0]      win_idx;
  logic                  any_eligible;
  logic [WID_W-1:0]      rr_ptr;
  logic [WID_W-1:0]      rr_ptr_next;
  logic                  en;
  logic                  pop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_unpack
      assign sin[gi] = '{
        wb:   ibuf_wb[gi],
        rd:   ibuf_rd[gi*RB +: RB],
        rs1:  ibuf_rs1[gi*RB +: RB],
        rs2:  ibuf_rs2[gi*RB +: RB],
        rs3:  ibuf_rs3[gi*RB +: RB],
        data: ibuf_data[gi*DATAW +: DATAW]
      };
    end
    for (gi = 0; gi < NUM_WB_PORTS; gi++) begin : g_wb
      // Only the final packet of a writeback frees its destination.
      assign rel[gi] = '{
        wid: wb_wid[gi*WID_W +: WID_W],
        rd:  wb_rd[gi*RB +: RB],
        eop: wb_valid[gi] & wb_eop[gi]
      };
    end
  endgenerate

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      clear_mask[w] = '0;
    end
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (rel[p].eop && rel[p].rd != '0) begin
        clear_mask[rel[p].wid][rel[p].rd] = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_elig
`ifdef ISSUE_WB_BYPASS_EN
      assign hazard_view[gi] = busy[gi] & ~clear_mask[gi];
`else
      assign hazard_view[gi] = busy[gi];
`endif
      // Register 0 is never marked busy, so x0 sources and destinations never block.
      assign eligible[gi] = ibuf_valid[gi]
                          & ~hazard_view[gi][sin[gi].rs1]
                          & ~hazard_view[gi][sin[gi].rs2]
                          & ~hazard_view[gi][sin[gi].rs3]
                          & ~(sin[gi].wb & hazard_view[gi][sin[gi].rd]);
    end
  endgenerate

  assign en = ~out_valid | out_ready;

  vx_rr_picker #(
    .NUM_REQS (NUM_WARPS)
  ) u_picker (
    .req      (eligible),
    .ptr      (rr_ptr),
    .en       (en & ~reset),
    .grant    (grant),
    .idx      (win_idx),
    .valid    (any_eligible),
    .ptr_next (rr_ptr_next)
  );

  assign ibuf_ready = grant;
  assign pop        = |grant;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      set_mask[w] = '0;
    end
    if (pop && sin[win_idx].wb && sin[win_idx].rd != '0) begin
      set_mask[win_idx][sin[win_idx].rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        busy[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        busy[w] <= (busy[w] & ~clear_mask[w]) | set_mask[w];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (pop) begin
      rr_ptr <= rr_ptr_next;
    end
  end

  // Output fields only move when the stage can advance, so they stay stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= any_eligible;
      if (any_eligible) begin
        out_wid  <= win_idx;
        out_data <= sin[win_idx].data;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (rel[p].eop && rel[p].rd != '0) begin
          assert (busy[rel[p].wid][rel[p].rd]);
        end
        for (int q = p + 1; q < NUM_WB_PORTS; q++) begin
          assert (!(rel[p].eop && rel[q].eop && rel[p].rd != '0 &&
                    rel[p].wid == rel[q].wid && rel[p].rd == rel[q].rd));
        end
      end
    end
  end
`endif

endmodule
